// File: rtl/serie_paralelo.sv
// Receive-side serial-to-parallel converter.
// Finds byte alignment on the idle comma, locks after a run of aligned
// commas, then rebuilds MSB-first bytes with a valid flag and a byte strobe.
module serie_paralelo #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned CCNT_W = 4;
   localparam logic [CCNT_W-1:0] LOCK_N   = CCNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_W - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_n;
   // Only the seven most recent bits are kept; the eighth is data_in itself.
   logic [BYTE_W-2:0]   hist;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_n;
   logic [CCNT_W-1:0]   commas;
   logic [CCNT_W-1:0]   commas_n;
   logic [BYTE_W-1:0]   data_n;
   logic                valid_n;
   logic                strobe_n;

   logic [BYTE_W-1:0]   nxt;
   logic                is_comma;
   logic                boundary;

   // Byte completed by the bit sampled at this edge.
   assign nxt      = {hist, data_in};
   assign is_comma = (nxt == COMMA);
   assign boundary = (cnt == LAST_BIT);

   // State, counters and registered outputs.
   always_ff @(posedge clk_8f or posedge reset) begin
      if (reset) begin
         state       <= SEARCH;
         hist        <= '0;
         cnt         <= '0;
         commas      <= '0;
         data_out    <= '0;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_n;
         hist        <= nxt[BYTE_W-2:0];
         cnt         <= cnt_n;
         commas      <= commas_n;
         data_out    <= data_n;
         valid_out   <= valid_n;
         byte_strobe <= strobe_n;
         active      <= (state_n == ACTIVE);
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      commas_n = commas;
      data_n   = data_out;
      valid_n  = valid_out;
      strobe_n = 1'b0;

      case (state)
         SEARCH: begin
            // Hunt for a comma at any bit offset; the match fixes the phase.
            if (is_comma) begin
               cnt_n    = '0;
               commas_n = CCNT_W'(1);
               state_n  = (LOCK_N == CCNT_W'(1)) ? ACTIVE : ALIGN;
            end
         end

         ALIGN: begin
            cnt_n = cnt + CNT_W'(1);
            if (boundary) begin
               if (is_comma) begin
                  if ((commas + CCNT_W'(1)) >= LOCK_N) begin
                     commas_n = LOCK_N;
                     state_n  = ACTIVE;
                  end else begin
                     commas_n = commas + CCNT_W'(1);
                  end
               end else begin
                  // Broken run: restart the hunt from the next edge.
                  commas_n = '0;
                  state_n  = SEARCH;
               end
            end
         end

         ACTIVE: begin
            // Phase is fixed for good; only reset leaves this state.
            cnt_n = cnt + CNT_W'(1);
            if (boundary) begin
               strobe_n = 1'b1;
               if (is_comma) begin
                  valid_n = 1'b0;
               end else begin
                  data_n  = nxt;
                  valid_n = 1'b1;
               end
            end
         end

         default: begin
            state_n = SEARCH;
         end
      endcase
   end

endmodule

// File: tb/tb_serie_paralelo.sv
// Bench for serie_paralelo: directed vector table, hand-written corner
// sequences and a randomized stream, all checked against a bit-history model.
module tb_serie_paralelo;

   localparam logic [7:0] BC = 8'hBC;

   logic       clk_8f  = 1'b0;
   logic       reset   = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] d0, d1;
   logic       v0, v1, s0, s1, a0, a1;

   int checks   = 0;
   int failures = 0;

   always #5 clk_8f = ~clk_8f;

   serie_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
      .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
      .data_out(d0), .valid_out(v0), .byte_strobe(s0), .active(a0)
   );

   serie_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(1)) dut1 (
      .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
      .data_out(d1), .valid_out(v1), .byte_strobe(s1), .active(a1)
   );

   // Reference model: mode 0=search 1=align 2=active, phase kept as the
   // edge index of the anchoring comma; boundaries are multiples of 8 from it.
   bit         hq[$];
   int         k;
   int         mode[2];
   int         anchor[2];
   int         commas[2];
   logic [7:0] md[2];
   logic       mv[2];
   logic       ms[2];
   int         lockv[2] = '{4, 1};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] last_byte();
      logic [7:0] r = '0;
      foreach (hq[i]) r = {r[6:0], hq[i]};
      return r;
   endfunction

   task automatic model_reset();
      hq.delete();
      k = 0;
      for (int m = 0; m < 2; m++) begin
         mode[m] = 0; anchor[m] = 0; commas[m] = 0;
         md[m] = 8'h00; mv[m] = 1'b0; ms[m] = 1'b0;
      end
   endtask

   task automatic model_step(input bit b);
      logic [7:0] byt;
      hq.push_back(b);
      if (hq.size() > 8) void'(hq.pop_front());
      byt = last_byte();
      for (int m = 0; m < 2; m++) begin
         ms[m] = 1'b0;
         case (mode[m])
            0: if (byt == BC) begin
                  anchor[m] = k;
                  commas[m] = 1;
                  mode[m]   = (lockv[m] == 1) ? 2 : 1;
               end
            1: if ((k - anchor[m]) % 8 == 0) begin
                  if (byt == BC) begin
                     commas[m]++;
                     if (commas[m] >= lockv[m]) mode[m] = 2;
                  end else begin
                     commas[m] = 0;
                     mode[m]   = 0;
                  end
               end
            default: if ((k - anchor[m]) % 8 == 0) begin
                  ms[m] = 1'b1;
                  if (byt != BC) begin
                     md[m] = byt;
                     mv[m] = 1'b1;
                  end else begin
                     mv[m] = 1'b0;
                  end
               end
         endcase
      end
      k++;
   endtask

   // Entered at a falling edge; returns at the next falling edge.
   task automatic send_bit(input bit b);
      data_in = b;
      @(posedge clk_8f);
      model_step(b);
      #1;
      chk("edge_lock4", {21'd0, a0, s0, v0, d0}, {21'd0, (mode[0] == 2), ms[0], mv[0], md[0]});
      chk("edge_lock1", {21'd0, a1, s1, v1, d1}, {21'd0, (mode[1] == 2), ms[1], mv[1], md[1]});
      @(negedge clk_8f);
   endtask

   task automatic send_byte(input logic [7:0] b, input int n = 8);
      for (int i = n - 1; i >= 0; i--) send_bit(b[i]);
   endtask

   // One-cycle reset pulse starting at a falling edge; outputs must clear at once.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_async", {16'd0, a0, s0, v0, d0, a1, s1, v1, d1}, 32'd0);
      @(negedge clk_8f);
      reset   = 1'b0;
      data_in = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [7:0] byt;
      int         nbits;
      logic       e_act;
      logic       e_stb;
      logic       e_val;
      logic [7:0] e_dat;
   } vec_t;

   vec_t tbl[17];
   int   stb_seen;
   int   nb;

   initial begin
      // Directed vectors for the LOCK_COUNT=4 instance.
      tbl[0]  = '{8'h05, 3, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{BC,    8, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{8'hA5, 8, 1'b1, 1'b1, 1'b1, 8'hA5};
      tbl[6]  = '{8'h3C, 8, 1'b1, 1'b1, 1'b1, 8'h3C};
      tbl[7]  = '{8'hA5, 8, 1'b1, 1'b1, 1'b1, 8'hA5};
      tbl[8]  = '{BC,    8, 1'b1, 1'b1, 1'b0, 8'hA5};
      tbl[9]  = '{8'h5A, 8, 1'b1, 1'b1, 1'b1, 8'h5A};
      tbl[10] = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[11] = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{8'h11, 8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[14] = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[15] = '{BC,    8, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[16] = '{BC,    8, 1'b1, 1'b0, 1'b0, 8'h00};

      @(negedge clk_8f);
      do_reset();

      // Idle zeros: no lock, no strobe, data stays clear.
      stb_seen = 0;
      for (int i = 0; i < 40; i++) begin
         send_bit(1'b0);
         stb_seen += int'(s0);
      end
      chk("idle_strobes", 32'(stb_seen), 32'd0);
      chk("idle_state", {23'd0, a0, d0}, 32'd0);

      // Table: lock with noise, data/comma reception, then broken-run relock.
      for (int i = 0; i < 17; i++) begin
         if (i == 10) do_reset();
         send_byte(tbl[i].byt, tbl[i].nbits);
         chk($sformatf("vec%0d", i), {21'd0, a0, s0, v0, d0},
             {21'd0, tbl[i].e_act, tbl[i].e_stb, tbl[i].e_val, tbl[i].e_dat});
      end

      // Reset mid-byte while active holding A5; relock needs four fresh commas.
      send_byte(8'hA5);
      chk("pre_rst_data", {23'd0, v0, d0}, {23'd0, 1'b1, 8'hA5});
      send_byte(8'h0B, 4);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_byte(BC);
         chk($sformatf("relock%0d", i), {31'd0, a0}, (i == 3) ? 32'd1 : 32'd0);
      end

      // LOCK_COUNT=1: one comma locks, first strobe one byte later.
      do_reset();
      send_byte(BC);
      chk("lock1_active", {30'd0, a1, s1}, {30'd0, 1'b1, 1'b0});
      send_byte(8'h77);
      chk("lock1_data", {21'd0, a1, s1, v1, d1}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h77});
      chk("lock1_main_idle", {31'd0, a0}, 32'd0);

      // Randomized streams: noise, comma run, mixed traffic with occasional bit slips.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         nb = $urandom_range(0, 7);
         for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
         nb = $urandom_range(1, 6);
         for (int i = 0; i < nb; i++) send_byte(BC);
         for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) == 0) send_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) send_byte(BC);
            else                           send_byte(8'($urandom()));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
